// File: rtl/soc_loader_pkg.sv
// rtl/soc_loader_pkg.sv - shared state, error and framing types for the IMEM UART loader
package soc_loader_pkg;

   typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM} ldr_state_t;

   typedef enum logic [1:0] {ERR_NONE, ERR_LEN, ERR_TMO, ERR_CSUM} ldr_err_t;

   localparam logic [7:0] LDR_MAGIC_DEF = 8'hA5;

endpackage

// File: rtl/imem_uart_loader_tmo.sv
// rtl/imem_uart_loader_tmo.sv - inter-byte gap timeout counter for UART-fed stages
// TIMEOUT_CYC of 0 removes the counter and expire stays low.
module imem_uart_loader_tmo #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic clk,
   input  logic arst_n,
   input  logic run,
   input  logic kick,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   generate
      if (TIMEOUT_CYC > 0) begin : g_tmo
         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;

         always_comb begin
            cnt_d = cnt_q + 1'b1;
            if (!run || kick) cnt_d = '0;
         end

         always_ff @(posedge clk) begin
            if (!arst_n) cnt_q <= '0;
            else         cnt_q <= cnt_d;
         end

         // Fires on the TIMEOUT_CYC-th quiet cycle; a kick in that cycle wins.
         assign expire = run && !kick && (cnt_q == CW'(TIMEOUT_CYC - 1));
      end else begin : g_off
         assign expire = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - framed UART byte stream to IMEM word writes, holds CPU in reset while loading
// IMEM_UART_LOADER_CSUM_EN adds the trailing checksum byte and its check.
module imem_uart_loader
   import soc_loader_pkg::*;
#(
   parameter logic [7:0] MAGIC       = LDR_MAGIC_DEF,
   parameter int         MAX_WORDS   = 8192,
   parameter int         TIMEOUT_CYC = 100000
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        rx_vld,
   input  logic [7:0]  rx_dat,
   output logic        imem_we,
   output logic [29:0] imem_waddr,
   output logic [31:0] imem_wdat,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

   ldr_state_t  state_q;
   ldr_err_t    err_code_q;
   logic [1:0]  b_q;
   logic [29:0] addr_q;
   logic [29:0] addr_d;
   logic [15:0] len_q;
   logic [15:0] len_d;
   logic [31:0] word_q;
   logic [31:0] word_d;
   logic        we_q;
   logic [29:0] waddr_q;
   logic [31:0] wdat_q;
   logic        busy_q;
   logic        hold_q;
   logic        done_q;
   logic        done_pend_q;
   logic        err_q;
   logic        tmo_expire;
`ifdef IMEM_UART_LOADER_CSUM_EN
   logic [7:0]  csum_q;
`endif

   imem_uart_loader_tmo #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_tmo (
      .clk   (clk),
      .arst_n(arst_n),
      .run   (state_q != IDLE),
      .kick  (rx_vld),
      .expire(tmo_expire)
   );

   // Little-endian field assembly: byte b lands at bits [8b+7:8b].
   always_comb begin
      addr_d = addr_q;
      case (b_q)
         2'd0:    addr_d[7:0]   = rx_dat;
         2'd1:    addr_d[15:8]  = rx_dat;
         2'd2:    addr_d[23:16] = rx_dat;
         default: addr_d[29:24] = rx_dat[5:0];
      endcase
   end

   always_comb begin
      word_d = word_q;
      word_d[{b_q, 3'b000} +: 8] = rx_dat;
   end

   assign len_d = {rx_dat, len_q[7:0]};

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q     <= IDLE;
         b_q         <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         word_q      <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdat_q      <= '0;
         busy_q      <= 1'b0;
         hold_q      <= 1'b0;
         done_q      <= 1'b0;
         done_pend_q <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
`ifdef IMEM_UART_LOADER_CSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         we_q        <= 1'b0;
         done_q      <= done_pend_q;
         done_pend_q <= 1'b0;
         if (tmo_expire) begin
            state_q    <= IDLE;
            b_q        <= '0;
            busy_q     <= 1'b0;
            hold_q     <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= ERR_TMO;
         end else if (rx_vld) begin
            case (state_q)
               IDLE: begin
                  if (rx_dat == MAGIC) begin
                     state_q    <= ADDR;
                     b_q        <= '0;
                     busy_q     <= 1'b1;
                     hold_q     <= 1'b1;
                     err_q      <= 1'b0;
                     err_code_q <= ERR_NONE;
`ifdef IMEM_UART_LOADER_CSUM_EN
                     csum_q     <= '0;
`endif
                  end
               end
               ADDR: begin
`ifdef IMEM_UART_LOADER_CSUM_EN
                  csum_q <= csum_q + rx_dat;
`endif
                  addr_q <= addr_d;
                  b_q    <= b_q + 2'd1;
                  if (b_q == 2'd3) state_q <= LEN;
               end
               LEN: begin
`ifdef IMEM_UART_LOADER_CSUM_EN
                  csum_q <= csum_q + rx_dat;
`endif
                  if (b_q == 2'd0) begin
                     len_q <= {8'h00, rx_dat};
                     b_q   <= 2'd1;
                  end else begin
                     len_q <= len_d;
                     b_q   <= '0;
                     if ({1'b0, len_d} > MAX_W) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        hold_q     <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_LEN;
                     end else if (len_d == 16'd0) begin
`ifdef IMEM_UART_LOADER_CSUM_EN
                        state_q <= CSUM;
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        hold_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                     end else begin
                        state_q <= DATA;
                     end
                  end
               end
               DATA: begin
`ifdef IMEM_UART_LOADER_CSUM_EN
                  csum_q <= csum_q + rx_dat;
`endif
                  word_q <= word_d;
                  b_q    <= b_q + 2'd1;
                  if (b_q == 2'd3) begin
                     we_q    <= 1'b1;
                     waddr_q <= addr_q;
                     wdat_q  <= word_d;
                     addr_q  <= addr_q + 30'd1;
                     len_q   <= len_q - 16'd1;
                     if (len_q == 16'd1) begin
`ifdef IMEM_UART_LOADER_CSUM_EN
                        state_q <= CSUM;
`else
                        // done trails the final write by one cycle
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        hold_q      <= 1'b0;
                        done_pend_q <= 1'b1;
`endif
                     end
                  end
               end
`ifdef IMEM_UART_LOADER_CSUM_EN
               CSUM: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  hold_q  <= 1'b0;
                  if (rx_dat == csum_q) begin
                     done_q <= 1'b1;
                  end else begin
                     err_q      <= 1'b1;
                     err_code_q <= ERR_CSUM;
                  end
               end
`endif
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  hold_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign imem_we    = we_q;
   assign imem_waddr = waddr_q;
   assign imem_wdat  = wdat_q;
   assign cpu_hold   = hold_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb/tb_imem_uart_loader.sv - self-checking bench for imem_uart_loader
module tb_imem_uart_loader;

   localparam int TMO = 40;
`ifdef IMEM_UART_LOADER_CSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        rx_vld = 1'b0;
   logic [7:0]  rx_dat = 8'h00;
   logic        imem_we;
   logic [29:0] imem_waddr;
   logic [31:0] imem_wdat;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   always #5 clk = ~clk;

   imem_uart_loader #(
      .MAGIC(8'hA5),
      .MAX_WORDS(8192),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk),
      .arst_n(arst_n),
      .rx_vld(rx_vld),
      .rx_dat(rx_dat),
      .imem_we(imem_we),
      .imem_waddr(imem_waddr),
      .imem_wdat(imem_wdat),
      .cpu_hold(cpu_hold),
      .busy(busy),
      .done(done),
      .err(err),
      .err_code(err_code)
   );

   typedef struct {
      logic [29:0] a;
      logic [31:0] d;
   } wr_t;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] len;
      logic [31:0] w0;
      logic [31:0] w1;
      int          nd;
      logic [7:0]  off;
      bit          sc;
      bit          garb;
      logic [1:0]  code;
      bit          dn;
      int          wt;
   } vec_t;

   wr_t  exp_q[$];
   wr_t  e_w;
   vec_t vecs[7];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   last_we_cyc = 0;
   int   base;
   logic prev_we = 1'b0;
   logic [7:0] run_sum;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_vld = 1'b1;
      rx_dat = b;
      @(posedge clk);
      #1;
      rx_vld = 1'b0;
   endtask

   task automatic send_cs(input logic [7:0] b);
      run_sum = run_sum + b;
      send_byte(b);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input vec_t v);
      logic [31:0] w;
      if (v.garb) begin
         send_byte(8'h00);
         send_byte(8'hFF);
         send_byte(8'h5A);
      end
      send_byte(8'hA5);
      run_sum = 8'h00;
      for (int i = 0; i < 4; i++) send_cs(v.addr[8*i +: 8]);
      for (int i = 0; i < 2; i++) send_cs(v.len[8*i +: 8]);
      for (int k = 0; k < v.nd; k++) begin
         w = (k == 0) ? v.w0 : v.w1;
         for (int i = 0; i < 4; i++) send_cs(w[8*i +: 8]);
         exp_q.push_back('{v.addr[29:0] + 30'(k), w});
      end
      if (CSUM_EN && v.sc) send_byte(run_sum + v.off);
   endtask

   task automatic check_idle_out(input string tag, input logic [1:0] code);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_hold"}, cpu_hold, 0);
      chk({tag, "_err"}, err, code != 2'd0);
      chk({tag, "_code"}, err_code, code);
      chk({tag, "_pending"}, exp_q.size(), 0);
   endtask

   task automatic tmo_seq(input bit byte_on_expiry);
      send_byte(8'hA5);
      run_sum = 8'h00;
      send_cs(8'h00); send_cs(8'h03); send_cs(8'h00); send_cs(8'h00);
      send_cs(8'h02); send_cs(8'h00);
      send_cs(8'hAA); send_cs(8'hBB);
      idle(TMO - 1);
      chk("tmo_not_early", busy, 1);
      if (!byte_on_expiry) begin
         idle(1);
         check_idle_out("tmo_fire", 2'd2);
      end else begin
         base = done_cnt;
         send_cs(8'hCC);
         send_cs(8'hDD);
         exp_q.push_back('{30'h300, 32'hDDCCBBAA});
         send_cs(8'h01); send_cs(8'h02); send_cs(8'h03); send_cs(8'h04);
         exp_q.push_back('{30'h301, 32'h04030201});
         if (CSUM_EN) send_byte(run_sum);
         idle(5);
         check_idle_out("tmo_win", 2'd0);
         chk("tmo_win_done", done_cnt - base, 1);
      end
   endtask

   initial begin
      vecs[0] = '{32'h0000_0010, 16'd2, 32'h4433_2211, 32'h8877_6655, 2, 8'd0, 1'b1, 1'b0, 2'd0, 1'b1, 5};
      vecs[1] = '{32'h0000_0100, 16'd8193, 32'h0, 32'h0, 0, 8'd0, 1'b0, 1'b0, 2'd1, 1'b0, 5};
      vecs[2] = '{32'hC000_0040, 16'd1, 32'hDEAD_BEEF, 32'h0, 1, 8'd0, 1'b1, 1'b0, 2'd0, 1'b1, 5};
      vecs[3] = '{32'h0000_0030, 16'd1, 32'h0102_0304, 32'h0, 1, 8'd1, 1'b1, 1'b0,
                  CSUM_EN ? 2'd3 : 2'd0, !CSUM_EN, 5};
      vecs[4] = '{32'h3FFF_FFFF, 16'd2, 32'hCAFE_BABE, 32'h1234_5678, 2, 8'd0, 1'b1, 1'b1, 2'd0, 1'b1, 5};
      vecs[5] = '{32'h0000_0077, 16'd0, 32'h0, 32'h0, 0, 8'd0, 1'b1, 1'b0, 2'd0, 1'b1, 5};
      vecs[6] = '{32'h0000_0200, 16'd8192, 32'h0, 32'h0, 0, 8'd0, 1'b0, 1'b0, 2'd2, 1'b0, TMO + 10};

      fork
         forever begin
            @(negedge clk);
            cyc++;
            if (arst_n) begin
               chk("hold_eq_busy", cpu_hold, busy);
               if (imem_we) begin
                  chk("we_single_cycle", prev_we, 0);
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_write waddr=%0h wdat=%0h required=none", imem_waddr, imem_wdat);
                  end else begin
                     e_w = exp_q.pop_front();
                     chk("waddr", 32'(imem_waddr), 32'(e_w.a));
                     chk("wdat", imem_wdat, e_w.d);
                  end
                  last_we_cyc = cyc;
               end
               if (done) begin
                  done_cnt++;
                  done_cyc = cyc;
               end
               prev_we = imem_we;
            end
         end
      join_none

      @(posedge clk);
      #1;
      idle(3);
      chk("rst_we", imem_we, 0);
      chk("rst_waddr", 32'(imem_waddr), 0);
      chk("rst_wdat", imem_wdat, 0);
      chk("rst_hold", cpu_hold, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_code", err_code, 0);
      arst_n = 1'b1;
      idle(2);

      for (int n = 0; n < 7; n++) begin
         base = done_cnt;
         send_frame(vecs[n]);
         idle(vecs[n].wt);
         check_idle_out($sformatf("vec%0d", n), vecs[n].code);
         chk($sformatf("vec%0d_done", n), done_cnt - base, vecs[n].dn ? 1 : 0);
         if (vecs[n].dn && vecs[n].nd > 0) chk($sformatf("vec%0d_done_lat", n), done_cyc - last_we_cyc, 1);
      end

      tmo_seq(1'b0);
      tmo_seq(1'b1);

      send_byte(8'hA5);
      send_byte(8'h50); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      arst_n = 1'b0;
      idle(1);
      chk("mid_rst_we", imem_we, 0);
      chk("mid_rst_waddr", 32'(imem_waddr), 0);
      chk("mid_rst_wdat", imem_wdat, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_hold", cpu_hold, 0);
      chk("mid_rst_done", done, 0);
      arst_n = 1'b1;
      send_byte(8'h44);
      idle(5);
      check_idle_out("post_rst", 2'd0);
      base = done_cnt;
      send_frame(vecs[2]);
      idle(5);
      check_idle_out("reload", 2'd0);
      chk("reload_done", done_cnt - base, 1);

      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
